// File: rtl/rr_selector_pkg.sv
// rtl/rr_selector_pkg.sv - shared mode constants and index helper for rr_selector
package rr_selector_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin priority search starting at ptr, wrapping at N-1
module rr_arbiter
  import rr_selector_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  always_comb begin : search
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[SELW'(idx)]) begin
        any                = 1'b1;
        grant[SELW'(idx)]  = 1'b1;
        grant_idx          = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_selector.sv
// rtl/rr_selector.sv - N-to-1 channel selector, fixed or round-robin, with registered output
module rr_selector
  import rr_selector_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SELW-1:0]     ptr;
  logic [CHANNELS-1:0] arb_grant;
  logic [SELW-1:0]     arb_idx;
  logic                arb_any;
  logic [CHANNELS-1:0] fixed_vec;
  logic [CHANNELS-1:0] take;
  logic                loadable;
  logic                xfer;
  logic [WIDTH-1:0]    mux_data;
  logic [SELW-1:0]     mux_chan;

  rr_arbiter #(.N(CHANNELS), .SELW(SELW)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // rst_n gates loadable so in_ready is silent during reset even though out_valid=0
  assign loadable = rst_n & (~out_valid | out_ready);

  always_comb begin
    fixed_vec = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      fixed_vec[k] = (sel == SELW'(k));
    end
  end

  always_comb begin
    in_ready = '0;
    if (loadable) begin
      if (mode == MODE_RR) begin
        in_ready = arb_any ? arb_grant : '0;
      end else begin
        in_ready = fixed_vec;
      end
    end
  end

  assign take = in_ready & in_valid;
  assign xfer = |take;

  // take is at most one-hot, so an OR-reduce mux is exact
  always_comb begin
    mux_data = '0;
    mux_chan = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (take[k]) begin
        mux_data = mux_data | in_data[k*WIDTH +: WIDTH];
        mux_chan = mux_chan | SELW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= mux_data;
      out_chan  <= mux_chan;
      out_valid <= 1'b1;
      if (mode == MODE_RR) begin
        ptr <= SELW'(wrap_next(int'(arb_idx), CHANNELS));
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_selector.sv
// tb/tb_rr_selector.sv - directed self-checking bench for rr_selector (4x8 and 3x16 instances)
module tb_rr_selector;

  logic        clk;
  logic        rst_n;

  logic        mode_a;
  logic [1:0]  sel_a;
  logic [31:0] in_data_a;
  logic [3:0]  in_valid_a;
  logic [3:0]  in_ready_a;
  logic [7:0]  out_data_a;
  logic [1:0]  out_chan_a;
  logic        out_valid_a;
  logic        out_ready_a;

  logic        mode_b;
  logic [1:0]  sel_b;
  logic [47:0] in_data_b;
  logic [2:0]  in_valid_b;
  logic [2:0]  in_ready_b;
  logic [15:0] out_data_b;
  logic [1:0]  out_chan_b;
  logic        out_valid_b;
  logic        out_ready_b;

  int n_checks = 0;
  int n_fail   = 0;

  rr_selector #(.WIDTH(8), .CHANNELS(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode_a),
    .sel       (sel_a),
    .in_data   (in_data_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .out_data  (out_data_a),
    .out_chan  (out_chan_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a)
  );

  rr_selector #(.WIDTH(16), .CHANNELS(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode_b),
    .sel       (sel_b),
    .in_data   (in_data_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .out_data  (out_data_b),
    .out_chan  (out_chan_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  da [4];
  logic [15:0] db [3];

  initial begin
    da = '{8'h5C, 8'h11, 8'hA5, 8'h33};
    db = '{16'h1234, 16'h5678, 16'hBEEF};

    rst_n       = 1'b0;
    mode_a      = 1'b1;
    sel_a       = 2'd0;
    in_data_a   = {da[3], da[2], da[1], da[0]};
    in_valid_a  = 4'b1111;
    out_ready_a = 1'b1;
    mode_b      = 1'b0;
    sel_b       = 2'd0;
    in_data_b   = {db[2], db[1], db[0]};
    in_valid_b  = 3'b000;
    out_ready_b = 1'b1;

    #3;
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_data",  32'(out_data_a),  32'd0);
    check("rst_out_chan",  32'(out_chan_a),  32'd0);
    check("rst_in_ready",  32'(in_ready_a),  32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    in_valid_a = 4'b0000;
    @(posedge clk);
    #1;

    // fixed select of channel 2
    mode_a = 1'b0; sel_a = 2'd2; in_valid_a = 4'b1111;
    #1 check("fix_in_ready", 32'(in_ready_a), 32'b0100);
    tick();
    check("fix_out_data",  32'(out_data_a),  32'hA5);
    check("fix_out_chan",  32'(out_chan_a),  32'd2);
    check("fix_out_valid", 32'(out_valid_a), 32'd1);
    in_valid_a = 4'b0000;
    tick();
    check("drain_out_valid", 32'(out_valid_a), 32'd0);

    // round-robin full throughput, ptr still 0 after fixed-mode transfer
    mode_a = 1'b1; in_valid_a = 4'b1111;
    #1 check("rr_first_ready", 32'(in_ready_a), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_seq_chan",  32'(out_chan_a),  32'(i % 4));
      check("rr_seq_data",  32'(out_data_a),  32'(da[i % 4]));
      check("rr_seq_valid", 32'(out_valid_a), 32'd1);
    end

    // move ptr to 3, then single request on 1 must wrap
    in_valid_a = 4'b0100;
    tick();
    check("ptr3_chan", 32'(out_chan_a), 32'd2);
    in_valid_a = 4'b0010;
    #1 check("wrap_ready", 32'(in_ready_a), 32'b0010);
    tick();
    check("wrap_chan", 32'(out_chan_a), 32'd1);
    in_valid_a = 4'b1111;
    #1 check("ptr2_ready", 32'(in_ready_a), 32'b0100);
    tick();
    check("ptr2_chan", 32'(out_chan_a), 32'd2);

    // no requests: ptr must stay at 3
    in_valid_a = 4'b0000;
    #1 check("idle_ready", 32'(in_ready_a), 32'd0);
    tick();
    check("idle_out_valid", 32'(out_valid_a), 32'd0);
    in_valid_a = 4'b1111;
    #1 check("idle_ptr_ready", 32'(in_ready_a), 32'b1000);
    tick();
    check("ptr3b_chan", 32'(out_chan_a), 32'd3);

    // backpressure hold while inputs and mode change underneath
    out_ready_a = 1'b0;
    in_data_a = 32'hC3C2C1C0;
    mode_a = 1'b0; sel_a = 2'd1;
    for (int i = 0; i < 5; i++) begin
      #1 check("hold_ready", 32'(in_ready_a), 32'd0);
      tick();
      check("hold_valid", 32'(out_valid_a), 32'd1);
      check("hold_chan",  32'(out_chan_a),  32'd3);
      check("hold_data",  32'(out_data_a),  32'h33);
    end
    out_ready_a = 1'b1;
    #1 check("refill_ready", 32'(in_ready_a), 32'b0010);
    tick();
    check("refill_data", 32'(out_data_a), 32'hC1);
    check("refill_chan", 32'(out_chan_a), 32'd1);
    mode_a = 1'b1;
    #1 check("ptr_kept_ready", 32'(in_ready_a), 32'b0001);
    tick();
    check("pre_rst_chan", 32'(out_chan_a), 32'd0);

    // asynchronous reset in mid-cycle with a held word
    out_ready_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid_a), 32'd0);
    check("arst_out_data",  32'(out_data_a),  32'd0);
    check("arst_in_ready",  32'(in_ready_a),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_a = 1'b1; in_valid_a = 4'b1111;
    #1 check("post_rst_ready", 32'(in_ready_a), 32'b0001);
    tick();
    check("post_rst_chan",  32'(out_chan_a),  32'd0);
    check("post_rst_valid", 32'(out_valid_a), 32'd1);

    // 3-channel instance: out-of-range sel gives no grant
    in_valid_a = 4'b0000;
    mode_b = 1'b0; sel_b = 2'd3; in_valid_b = 3'b111;
    #1 check("b_sel3_ready", 32'(in_ready_b), 32'd0);
    tick();
    check("b_sel3_valid", 32'(out_valid_b), 32'd0);
    tick();
    check("b_sel3_valid2", 32'(out_valid_b), 32'd0);
    sel_b = 2'd2;
    #1 check("b_sel2_ready", 32'(in_ready_b), 32'b100);
    tick();
    check("b_sel2_data", 32'(out_data_b), 32'hBEEF);
    check("b_sel2_chan", 32'(out_chan_b), 32'd2);
    mode_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_rr_chan", 32'(out_chan_b), 32'(i % 3));
      check("b_rr_data", 32'(out_data_b), 32'(db[i % 3]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_selector.md
RR_SELECTOR -- requirements
Module: rr_selector

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel.
REQ-002 Parameter CHANNELS, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SELW, default $clog2(CHANNELS), width of channel index.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = fixed select (uses sel), 1 = round-robin arbitration.
REQ-007 sel  input  SELW  channel index used when mode=0.
REQ-008 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel data valid.
REQ-010 in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SELW  index of channel that supplied out_data.
REQ-013 out_valid  output  1  output register holds data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Transfer on any port occurs only in a cycle where valid and ready are both high at the clock edge.
REQ-016 Output register is "loadable" when out_valid=0 or out_ready=1 (same-cycle drain and refill allowed).
REQ-017 in_ready is all-zero when output register is not loadable.
REQ-018 mode=0: in_ready[sel]=loadable, all other bits 0; sel >= CHANNELS yields no grant.
REQ-019 mode=1: grant goes to the first channel with in_valid=1 searching upward from pointer ptr, wrapping CHANNELS-1 -> 0; in_ready[grant]=loadable.
REQ-020 in_ready is combinational from in_valid, mode, sel, ptr, out_valid, out_ready; it shall not depend on in_data.
REQ-021 On a transfer from channel g: out_data <= channel g data, out_chan <= g, out_valid <= 1 next cycle (latency 1 cycle).
REQ-022 ptr updates to (g+1) mod CHANNELS only on a transfer in mode=1; unchanged otherwise, including in mode=0.
REQ-023 If out_ready=1 and no input transfer occurs, out_valid <= 0 next cycle.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_chan, out_valid shall hold stable.
REQ-025 No in_valid high in mode=1: in_ready all-zero, ptr unchanged.
REQ-026 mode or sel change mid-stream affects only the next grant; the held output register is unaffected.
REQ-027 Full throughput: with continuous valid inputs and out_ready=1, one transfer per cycle.

Reset
REQ-028 rst_n low asynchronously forces out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-029 in_ready shall be all-zero while rst_n is low.
REQ-030 Reset asserted mid-transfer discards the held word; first grant after release in mode=1 starts search at channel 0.

Structure
REQ-031 Shared package rr_selector_pkg holds mode constants MODE_FIXED=0, MODE_RR=1.
REQ-032 Round-robin priority search is one sub-module, rr_arbiter (inputs req, ptr; outputs one-hot grant, grant index, any).
REQ-033 Datapath mux and output register live in rr_selector; no latches, no tristates.

Verification
REQ-034 mode=0, sel=2, in_valid=4'b1111, channel 2 data 8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2, out_valid=1.
REQ-035 mode=1, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, one per cycle.
REQ-036 mode=1, ptr=3, in_valid=4'b0010 -> grant channel 1 (wrap), ptr becomes 2.
REQ-037 out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data/out_chan unchanged; out_ready=1 -> same-cycle refill, new word next cycle.
REQ-038 rst_n pulled low mid-cycle with out_valid=1 -> out_valid=0 immediately, no clock edge needed; after release first mode=1 grant with all valid is channel 0.
REQ-039 CHANNELS=3, WIDTH=16, mode=0, sel=3 -> in_ready=3'b000, out_valid stays 0.
